// File: rtl/count_seq_checker_pkg.sv
// Shared types and default sizing for the count sequence checker.
package count_seq_checker_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int STABLE_DEF = 2;
    localparam int ERR_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK,
        ERROR
    } state_t;

endpackage

// File: rtl/count_stability_filter.sv
// Two-flop synchronizer plus run-length filter for a rippling count bus.
module count_stability_filter
    import count_seq_checker_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int STABLE_CYCLES = STABLE_DEF
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] ref_val,
    output logic [WIDTH-1:0] acc_val,
    output logic             acc_stb
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [3:0]       run;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            run   <= '0;
        end else begin
            sync1 <= cnt_in;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                run  <= 4'd1;
            end else if (run != RUN_MAX) begin
                run <= run + 4'd1;
            end
        end
    end

    // Strobe lasts one cycle: the top loads ref_val from acc_val on it.
    assign acc_val = cand;
    assign acc_stb = (run == RUN_MAX) && (cand != ref_val);

endmodule

// File: rtl/count_seq_checker.sv
// Settled-count tracker: checks single steps, flags wraps and errors.
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int STABLE_CYCLES = STABLE_DEF,
    parameter int ERR_W         = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             enable,
    input  logic             mode_up,
    input  logic             resync,
    input  logic             err_clr,
    output logic [WIDTH-1:0] cnt_q,
    output logic             locked,
    output logic             step_evt,
    output logic             wrap_evt,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [WIDTH-1:0] ONE  = 1;
    localparam logic [WIDTH-1:0] MAXV = '1;
    localparam logic [ERR_W-1:0] EONE = 1;
    localparam logic [ERR_W-1:0] EMAX = '1;

    state_t           state;
    state_t           state_n;
    logic             mode_q;
    logic [WIDTH-1:0] acc_val;
    logic             acc_stb;
    logic [WIDTH-1:0] exp_val;
    logic             wrap_c;
    logic             step_n;
    logic             wrap_n;
    logic             err_n;
    logic [ERR_W-1:0] ec_n;

    count_stability_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filt (
        .clk     (clk),
        .clear_n (clear_n),
        .cnt_in  (cnt_in),
        .ref_val (cnt_q),
        .acc_val (acc_val),
        .acc_stb (acc_stb)
    );

    assign exp_val = mode_up ? cnt_q + ONE : cnt_q - ONE;
    assign wrap_c  = mode_up ? (cnt_q == MAXV) : (cnt_q == '0);

    always_comb begin
        state_n = state;
        step_n  = 1'b0;
        wrap_n  = 1'b0;
        err_n   = 1'b0;
        if (!enable) begin
            state_n = IDLE;
        end else if (resync) begin
            state_n = ACQUIRE;
        end else if (state == TRACK && mode_up != mode_q) begin
            state_n = ACQUIRE;
        end else begin
            unique case (state)
                IDLE: state_n = ACQUIRE;
                ACQUIRE, ERROR: begin
                    if (acc_stb) state_n = TRACK;
                end
                TRACK: begin
                    if (acc_stb) begin
                        if (acc_val == exp_val) begin
                            step_n = 1'b1;
                            wrap_n = wrap_c;
                        end else begin
                            err_n   = 1'b1;
                            state_n = ERROR;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Clear wins over the old count but not over a same-cycle error.
    always_comb begin
        ec_n = err_count;
        if (err_clr) begin
            ec_n = err_n ? EONE : '0;
        end else if (err_n && err_count != EMAX) begin
            ec_n = err_count + EONE;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            cnt_q     <= '0;
            step_evt  <= 1'b0;
            wrap_evt  <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            mode_q    <= mode_up;
            if (acc_stb) cnt_q <= acc_val;
            step_evt  <= step_n;
            wrap_evt  <= wrap_n;
            err_pulse <= err_n;
            err_count <= ec_n;
        end
    end

    assign locked = (state == TRACK);

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Reader-side companion to the team's ripple up/down counters.
- Samples a free-running, asynchronously rippling WIDTH-bit count bus into the clk domain and filters ripple transients.
- Tracks the settled count and checks that each new value is exactly one step in the expected direction; flags steps, wrap-arounds and sequence errors.
- Sits between any counter instance and the status/monitor logic.

Parameters:
- WIDTH, 4, width of the observed count bus.
- STABLE_CYCLES, 2, number of consecutive identical synchronized samples (1..15) required before a value is accepted.
- ERR_W, 4, width of the saturating error counter.

Ports:
- clk  in  1  sampling clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- cnt_in  in  WIDTH  raw count bus from the counter; asynchronous to clk.
- enable  in  1  checker active when 1.
- mode_up  in  1  expected direction: 1 = increment, 0 = decrement.
- resync  in  1  single-cycle request to re-acquire the reference without flagging an error.
- err_clr  in  1  synchronous clear of err_count.
- cnt_q  out  WIDTH  last accepted, settled count.
- locked  out  1  1 while in TRACK.
- step_evt  out  1  one-cycle pulse on a correct single step.
- wrap_evt  out  1  one-cycle pulse on a correct step that wraps (max→0 when up, 0→max when down).
- err_pulse  out  1  one-cycle pulse on a sequence error.
- err_count  out  ERR_W  saturating count of sequence errors.

Behaviour:
- Reset (clear_n=0, async): all state flops 0, state IDLE; cnt_q=0, locked=0, all pulses 0, err_count=0.
- Input path: cnt_in passes through a 2-flop synchronizer into a stability filter.
  - Filter holds a candidate value and a run counter.
  - Run counter resets to 1 when the synchronized sample differs from the candidate; otherwise it increments, saturating at STABLE_CYCLES.
  - A value is "accepted" in the cycle the run counter reaches STABLE_CYCLES and the candidate differs from cnt_q.
  - Only accepted values reach the FSM. A bounce shorter than STABLE_CYCLES is never accepted.
- Latency: a cnt_in value first sampled at edge E and held stable updates cnt_q at edge E+STABLE_CYCLES+2. Event pulses assert in the same cycle cnt_q updates.
- FSM states: IDLE, ACQUIRE, TRACK, ERROR.
  - IDLE: cnt_q still follows accepted values; no events. enable=1 → ACQUIRE.
  - ACQUIRE: the next accepted value loads cnt_q with no check → TRACK.
  - TRACK: for each accepted value v, exp = cnt_q+1 (mode_up=1) or cnt_q−1 (mode_up=0), modulo 2^WIDTH.
    - v==exp: step_evt=1; wrap_evt=1 as well if the step wraps. Stay in TRACK.
    - v!=exp: err_pulse=1, err_count increments (saturating at 2^ERR_W−1), go to ERROR.
    - cnt_q always loads v.
  - ERROR: the next accepted value is loaded as the new reference with no check → TRACK.
- Priority, highest first:
  1. enable=0 → IDLE from any state. err_count is retained.
  2. resync=1 → ACQUIRE. An accepted value in the same cycle is loaded unchecked.
  3. A mode_up change while in TRACK → ACQUIRE with no error. Detected against mode_up registered the previous cycle.
  4. Normal transitions.
- err_clr: err_count=0. If an error occurs in the same cycle, err_count=1.
- Counter clear seen in TRACK (value jumps to 0 off-sequence) counts as an error unless resync was issued first. Exception: 0 is the legitimate up-wrap from max.
- clear_n asserted mid-operation returns everything to reset values immediately; operation resumes in IDLE.

Decomposition:
- Shared package: state enum (IDLE/ACQUIRE/TRACK/ERROR), default WIDTH/STABLE_CYCLES/ERR_W constants.
- One sub-module: count_stability_filter (2-flop synchronizer + run-length filter; outputs accepted value and accept strobe). The FSM and check logic stay in the top.

Test Plan:
- Reset, then enable=1, mode_up=1; cnt_in steps 3,4,5 every 10 cycles → cnt_q=3 after acquire with no step_evt; then step_evt on 4 and on 5; err_count=0; cnt_q lags each cnt_in change by 4 edges.
- mode_up=1 sequence 14,15,0,1 → step_evt on each of 15, 0 and 1; wrap_evt only on 0. Repeat with mode_up=0 over 1,0,15 → wrap_evt only on 15.
- In TRACK at 6, cnt_in jumps to 9 → err_pulse once, err_count=1, state ERROR; then 10 → reloaded with no event; then 11 → step_evt.
- cnt_in glitches 5→7→6 with 7 held for 1 cycle (STABLE_CYCLES=2) → 7 never accepted; step_evt on 6; no error.
- At 8 in TRACK, pulse resync, then cnt_in=0 → no error, locked returns to 1. Separately, toggle mode_up at 8 then cnt_in=7 → no error, re-lock at 7.
- Force 15 errors, then 2 more → err_count saturates at 15. Assert err_clr together with an error → err_count=1. Drop clear_n mid-TRACK → all outputs 0 asynchronously.
